// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        START    = 2'd0,
        ALLOCATE = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;

    function automatic int tag_width(input int addr_w, input int set_bits);
        return addr_w - 2 - set_bits;
    endfunction

    // Highest proc_addr bit that belongs to the set index.
    function automatic int index_hi(input int set_bits);
        return set_bits + 1;
    endfunction

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int plru_width(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational pseudo-LRU for one set: MRU update for an accessed way and victim pick.
module plru_tree
    import icache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [plru_width(WAYS)-1:0] bits,
    input  logic [way_width(WAYS)-1:0]  access_way,
    output logic [plru_width(WAYS)-1:0] new_bits,
    output logic [way_width(WAYS)-1:0]  victim
);

    generate
        if (WAYS == 4) begin : g_tree4
            // bit0 picks the pair to evict from, bit1/bit2 the way inside pair 0-1 / 2-3.
            always_comb begin
                new_bits    = bits;
                new_bits[0] = ~access_way[1];
                if (access_way[1]) begin
                    new_bits[2] = ~access_way[0];
                end else begin
                    new_bits[1] = ~access_way[0];
                end
                victim = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
            end
        end else if (WAYS == 2) begin : g_tree2
            // The single bit names the way that was not most recently used.
            always_comb begin
                new_bits = ~access_way;
                victim   = bits;
            end
        end else begin : g_direct
            always_comb begin
                new_bits = '0;
                victim   = '0;
            end
        end
    endgenerate

endmodule

// File: rtl/icache_sa_ro.sv
// Set-associative read-only instruction cache with PLRU replacement, fence.i flush
// and access/miss counters, between the fetch stage and instruction memory.
module icache_sa_ro
    import icache_pkg::*;
#(
    parameter int SET_BITS = 3,
    parameter int WAYS     = 2,
    parameter int ADDR_W   = 30
) (
    input  logic                 clk,
    input  logic                 proc_reset,
    input  logic [ADDR_W-1:0]    proc_addr,
    output logic [31:0]          proc_rdata,
    output logic                 proc_stall,
    input  logic                 flush,
    output logic                 mem_read,
    output logic [ADDR_W-3:0]    mem_addr,
    input  logic [BLOCK_W-1:0]   mem_rdata,
    input  logic                 mem_ready,
    output logic [31:0]          access_cnt,
    output logic [31:0]          miss_cnt
);

    localparam int TAG_W    = tag_width(ADDR_W, SET_BITS);
    localparam int NUM_SETS = 1 << SET_BITS;
    localparam int WAY_W    = way_width(WAYS);
    localparam int PLRU_W   = plru_width(WAYS);
    localparam int IDX_HI   = index_hi(SET_BITS);

    state_t               state_q, state_d;
    logic [WAYS-1:0]      valid_q [NUM_SETS];
    logic [TAG_W-1:0]     tag_q   [NUM_SETS][WAYS];
    logic [BLOCK_W-1:0]   data_q  [NUM_SETS][WAYS];
    logic [PLRU_W-1:0]    plru_q  [NUM_SETS];
    logic [WAY_W-1:0]     victim_q;
    logic                 flush_pend_q;
    logic [31:0]          access_q;
    logic [31:0]          miss_q;

    logic [1:0]           offset;
    logic [SET_BITS-1:0]  index;
    logic [TAG_W-1:0]     tag;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     victim_d;
    logic                 found_invalid;
    logic [WAY_W-1:0]     plru_access;
    logic [PLRU_W-1:0]    plru_next;
    logic [WAY_W-1:0]     plru_victim;
    logic                 do_hit, do_miss, do_fill, do_flush;

    assign offset     = proc_addr[1:0];
    assign index      = proc_addr[IDX_HI:2];
    assign tag        = proc_addr[ADDR_W-1:IDX_HI+1];
    assign mem_addr   = proc_addr[ADDR_W-1:2];
    assign access_cnt = access_q;
    assign miss_cnt   = miss_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[index][w] && (tag_q[index][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Empty ways fill lowest-first; PLRU only decides once the set is full.
    always_comb begin
        victim_d      = plru_victim;
        found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_q[index][w]) begin
                victim_d      = WAY_W'(w);
                found_invalid = 1'b1;
            end
        end
    end

    assign plru_access = (state_q == ALLOCATE) ? victim_q : hit_way;

    plru_tree #(
        .WAYS(WAYS)
    ) u_plru (
        .bits      (plru_q[index]),
        .access_way(plru_access),
        .new_bits  (plru_next),
        .victim    (plru_victim)
    );

    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b1;
        proc_rdata = '0;
        mem_read   = 1'b0;
        do_hit     = 1'b0;
        do_miss    = 1'b0;
        do_fill    = 1'b0;
        do_flush   = 1'b0;
        case (state_q)
            START: begin
                if (flush_pend_q) begin
                    state_d = FLUSH;
                end else if (hit) begin
                    proc_stall = 1'b0;
                    proc_rdata = data_q[index][hit_way][{offset, 5'b0} +: WORD_W];
                    do_hit     = 1'b1;
                end else begin
                    do_miss = 1'b1;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    do_fill = 1'b1;
                    state_d = START;
                end else begin
                    mem_read = 1'b1;
                end
            end
            FLUSH: begin
                do_flush = 1'b1;
                state_d  = START;
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q      <= START;
            flush_pend_q <= 1'b0;
            victim_q     <= '0;
            access_q     <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            // A flush request arriving during the FLUSH cycle itself is kept.
            flush_pend_q <= flush | (flush_pend_q & ~do_flush);
            if (do_hit) begin
                access_q <= access_q + 32'd1;
            end
            if (do_miss) begin
                miss_q   <= miss_q + 32'd1;
                victim_q <= victim_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset || do_flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (do_fill) begin
                valid_q[index][victim_q] <= 1'b1;
            end
            if (do_fill || do_hit) begin
                plru_q[index] <= plru_next;
            end
        end
    end

    // Payload needs no reset: it is only visible through a set valid bit.
    always_ff @(posedge clk) begin
        if (do_fill && !proc_reset) begin
            tag_q[index][victim_q]  <= tag;
            data_q[index][victim_q] <= mem_rdata;
        end
    end

endmodule
